// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared constants and types for the iterative RV32M divide/remainder unit.
//   - operand width and iteration counter width
//   - funct3[1:0] operation encodings (DIV, DIVU, REM, REMU)
//   - FSM state encodings (IDLE, CALC, FIN)
//   - fixed results for divide-by-zero and signed overflow
//   - a small two's-complement negate helper
// No ports (package).
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    // funct3[1:0] of the M-extension divide group.
    // Bit 0 set means unsigned, bit 1 set means remainder.
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Architecturally defined results for the corner cases.
    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

    // Sign bookkeeping captured at acceptance and applied at the end.
    typedef struct packed {
        logic neg_quo;  // quotient must be negated (operand signs differ)
        logic neg_rem;  // remainder must be negated (dividend negative)
    } div_sign_t;

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

endpackage : div_unit_pkg

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Request/response bundle between the EX-stage issue logic and div_unit.
//   START      request, sampled only while the unit is idle
//   OP         funct3[1:0] operation select
//   OPERAND_A  dividend (rs1 data)
//   OPERAND_B  divisor (rs2 data)
//   DEST_ADDR  rd address captured with START
//   FLUSH      kill any in-flight operation
//   BUSY       operation accepted and not yet finished
//   DONE       one-cycle pulse, RESULT/WB_ADDRESS valid
//   RESULT     quotient or remainder
//   WB_ADDRESS captured DEST_ADDR, held with RESULT
// Modports: master = issuer (pipeline), slave = divider.
// -----------------------------------------------------------------------------
interface div_unit_if;
    import div_unit_pkg::*;

    logic            START;
    logic [1:0]      OP;
    logic [XLEN-1:0] OPERAND_A;
    logic [XLEN-1:0] OPERAND_B;
    logic [4:0]      DEST_ADDR;
    logic            FLUSH;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;
    logic [4:0]      WB_ADDRESS;

    modport master (
        output START, OP, OPERAND_A, OPERAND_B, DEST_ADDR, FLUSH,
        input  BUSY, DONE, RESULT, WB_ADDRESS
    );

    modport slave (
        input  START, OP, OPERAND_A, OPERAND_B, DEST_ADDR, FLUSH,
        output BUSY, DONE, RESULT, WB_ADDRESS
    );

endinterface : div_unit_if

// File: rtl/div_special_case.sv
// -----------------------------------------------------------------------------
// div_special_case
// Combinational detection of the two cases that bypass the iterative loop:
// divide-by-zero and signed overflow (INT_MIN / -1), plus their fixed result.
// Ports:
//   op_i        funct3[1:0] operation select
//   a_i         dividend
//   b_i         divisor
//   special_o   1 when the fast path applies
//   result_o    fast-path result (only meaningful when special_o = 1)
// -----------------------------------------------------------------------------
module div_special_case
    import div_unit_pkg::*;
(
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            special_o,
    output logic [XLEN-1:0] result_o
);

    logic is_signed;
    logic is_rem;
    logic div_zero;
    logic overflow;

    assign is_signed = ~op_i[0];
    assign is_rem    = op_i[1];
    assign div_zero  = (b_i == '0);
    // Only the signed forms can overflow; -1 as divisor is all ones.
    assign overflow  = is_signed && (a_i == INT_MIN) && (b_i == '1);

    assign special_o = div_zero | overflow;

    always_comb begin
        result_o = '0;
        if (div_zero) begin
            // Quotient is all ones, remainder is the untouched dividend.
            result_o = is_rem ? a_i : DIV_ZERO_Q;
        end else if (overflow) begin
            result_o = is_rem ? '0 : INT_MIN;
        end
    end

endmodule : div_special_case

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU), radix-2
// restoring, one quotient bit per clock. Operations work on magnitudes; the
// sign of the quotient/remainder is recorded at acceptance and applied in the
// final state. Divide-by-zero and signed overflow complete in a single edge
// without ever raising BUSY.
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RESET  synchronous active-high reset
//   bus    div_unit_if slave modport (request, flush, result, status)
// Timing: normal operations raise DONE 33 edges after acceptance, fast-path
// operations one edge after acceptance. RESULT/WB_ADDRESS hold until the next
// completion.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
(
    input  logic      CLK,
    input  logic      RESET,
    div_unit_if.slave bus
);

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    logic [1:0]       op_q,      op_d;
    logic [4:0]       dest_q,    dest_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [XLEN-1:0]  rem_q,     rem_d;
    logic [XLEN-1:0]  quo_q,     quo_d;
    logic [XLEN-1:0]  dvsr_q,    dvsr_d;
    div_sign_t        sign_q,    sign_d;
    logic [XLEN-1:0]  result_q,  result_d;
    logic [4:0]       wb_addr_q, wb_addr_d;
    logic             done_q,    done_d;

    // ---------------------------------------------------------------------
    // Fast-path detection on the live request operands
    // ---------------------------------------------------------------------
    logic            special;
    logic [XLEN-1:0] special_result;

    div_special_case u_special (
        .op_i      (bus.OP),
        .a_i       (bus.OPERAND_A),
        .b_i       (bus.OPERAND_B),
        .special_o (special),
        .result_o  (special_result)
    );

    // ---------------------------------------------------------------------
    // Acceptance: magnitudes and result signs of the incoming operands
    // ---------------------------------------------------------------------
    logic            req_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            accept;

    assign req_signed = ~bus.OP[0];
    assign a_neg      = req_signed & bus.OPERAND_A[XLEN-1];
    assign b_neg      = req_signed & bus.OPERAND_B[XLEN-1];
    assign abs_a      = a_neg ? twos_neg(bus.OPERAND_A) : bus.OPERAND_A;
    assign abs_b      = b_neg ? twos_neg(bus.OPERAND_B) : bus.OPERAND_B;

    // FLUSH wins over a simultaneous START.
    assign accept = (state_q == ST_IDLE) && bus.START && !bus.FLUSH;

    // ---------------------------------------------------------------------
    // One restoring step: shift {rem,quo} left, then trial-subtract the
    // divisor from the widened partial remainder. The extra top bit both
    // holds the bit shifted out of rem and acts as the borrow flag.
    // ---------------------------------------------------------------------
    logic [XLEN:0]   partial;
    logic [XLEN:0]   trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;

    assign partial  = {rem_q, quo_q[XLEN-1]};
    assign trial    = partial - {1'b0, dvsr_q};
    assign trial_ok = ~trial[XLEN];
    assign rem_step = trial_ok ? trial[XLEN-1:0] : partial[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], trial_ok};

    // ---------------------------------------------------------------------
    // Final sign correction and quotient/remainder select
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;
    logic [XLEN-1:0] final_result;

    assign quo_fixed    = sign_q.neg_quo ? twos_neg(quo_q) : quo_q;
    assign rem_fixed    = sign_q.neg_rem ? twos_neg(rem_q) : rem_q;
    assign final_result = op_q[1] ? rem_fixed : quo_fixed;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dest_d    = dest_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        sign_d    = sign_q;
        result_d  = result_q;
        wb_addr_d = wb_addr_q;
        done_d    = 1'b0;

        if (bus.FLUSH) begin
            // Abandon whatever is in flight; the last RESULT stays visible.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_d   = bus.OP;
                        dest_d = bus.DEST_ADDR;
                        if (special) begin
                            result_d  = special_result;
                            wb_addr_d = bus.DEST_ADDR;
                            done_d    = 1'b1;
                        end else begin
                            state_d        = ST_CALC;
                            cnt_d          = '0;
                            rem_d          = '0;
                            quo_d          = abs_a;
                            dvsr_d         = abs_b;
                            sign_d.neg_quo = a_neg ^ b_neg;
                            sign_d.neg_rem = a_neg;
                        end
                    end
                end

                ST_CALC: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = ST_FIN;
                    end
                end

                ST_FIN: begin
                    result_d  = final_result;
                    wb_addr_d = dest_q;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            dest_q    <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            sign_q    <= '0;
            result_q  <= '0;
            wb_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dest_q    <= dest_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            sign_q    <= sign_d;
            result_q  <= result_d;
            wb_addr_q <= wb_addr_d;
            done_q    <= done_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // BUSY covers every non-idle state, so it is high from the acceptance
    // edge through the FIN edge and never on the fast path.
    assign bus.BUSY       = (state_q != ST_IDLE);
    assign bus.DONE       = done_q;
    assign bus.RESULT     = result_q;
    assign bus.WB_ADDRESS = wb_addr_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Scoreboard bench for div_unit: the stimulus side pushes the expected result,
// destination and completion cycle of each tracked request; a monitor pops and
// compares whenever DONE is seen. Expected values come from plain signed and
// unsigned arithmetic with the RV32M corner-case rules.
// -----------------------------------------------------------------------------
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_unit_if bus();

    div_unit dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  addr;
        int          cyc;
        logic [1:0]  op;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RV32M semantics with plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] r;
        case (op)
            DIV_OP_DIV: begin
                if (b == 0)                                    r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else                                           r = $signed(a) / $signed(b);
            end
            DIV_OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIV_OP_REM: begin
                if (b == 0)                                    r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else                                           r = $signed(a) % $signed(b);
            end
            default:     r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Monitor: one line per completed transaction.
    always @(negedge clk) begin
        if (!rst && bus.DONE) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got DONE with RESULT %h, required no DONE", bus.RESULT);
            end else begin
                mon_e = sb.pop_front();
                check("result",  bus.RESULT, mon_e.res);
                check("wb_addr", {27'd0, bus.WB_ADDRESS}, {27'd0, mon_e.addr});
                check("latency", 32'(cyc), 32'(mon_e.cyc));
                $display("[TB] op=%0d result=%h rd=%0d cycle=%0d", mon_e.op, bus.RESULT,
                         bus.WB_ADDRESS, cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the acceptance edge,
    // with the request inputs scrambled to show they are not re-sampled.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input bit track);
        exp_t e;
        bus.START     = 1'b1;
        bus.OP        = op;
        bus.OPERAND_A = a;
        bus.OPERAND_B = b;
        bus.DEST_ADDR = d;
        if (track) begin
            e.res  = ref_result(op, a, b);
            e.addr = d;
            e.cyc  = cyc + 1 + (is_fast(op, a, b) ? 0 : 33);
            e.op   = op;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.START     = 1'b0;
        bus.OP        = 2'($urandom);
        bus.OPERAND_A = $urandom;
        bus.OPERAND_B = $urandom;
        bus.DEST_ADDR = 5'($urandom);
    endtask

    // Issue, then count the cycles BUSY stays high (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
        int n;
        issue(op, a, b, d, 1'b1);
        n = 0;
        while (bus.BUSY && n < 60) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), is_fast(op, a, b) ? 32'd0 : 32'd33);
    endtask

    initial begin
        logic [31:0] saved;
        int          n;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.START     = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.OP        = 2'd0;
        bus.OPERAND_A = 32'd0;
        bus.OPERAND_B = 32'd0;
        bus.DEST_ADDR = 5'd0;

        repeat (3) @(negedge clk);
        check("reset_busy",   {31'd0, bus.BUSY}, 32'd0);
        check("reset_done",   {31'd0, bus.DONE}, 32'd0);
        check("reset_result", bus.RESULT, 32'd0);
        check("reset_wb",     {27'd0, bus.WB_ADDRESS}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, issued back to back (each starts in the DONE cycle).
        run_op(DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,  5'd1);
        run_op(DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,  5'd2);
        run_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd7);
        run_op(DIV_OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd7);
        run_op(DIV_OP_DIV,  32'd5,         32'd0,  5'd3);
        run_op(DIV_OP_REMU, 32'd5,         32'd0,  5'd4);
        run_op(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
        run_op(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        run_op(DIV_OP_DIVU, 32'd7,         32'd100, 5'd0);

        // FLUSH on the 10th CALC cycle: no DONE, RESULT unchanged.
        saved = bus.RESULT;
        issue(DIV_OP_DIVU, 32'd1234567, 32'd3, 5'd9, 1'b0);
        repeat (9) @(negedge clk);
        bus.FLUSH = 1'b1;
        @(negedge clk);
        bus.FLUSH = 1'b0;
        check("flush_busy",   {31'd0, bus.BUSY}, 32'd0);
        check("flush_result", bus.RESULT, saved);
        repeat (40) @(negedge clk);
        check("flush_result_hold", bus.RESULT, saved);
        run_op(DIV_OP_DIVU, 32'd100, 32'd7, 5'd11);

        // FLUSH together with START in IDLE: request dropped.
        bus.FLUSH = 1'b1;
        issue(DIV_OP_DIV, 32'd50, 32'd5, 5'd12, 1'b0);
        bus.FLUSH = 1'b0;
        check("flush_start_busy", {31'd0, bus.BUSY}, 32'd0);
        repeat (3) @(negedge clk);

        // START while BUSY is ignored.
        issue(DIV_OP_DIV, 32'd1000, 32'd7, 5'd3, 1'b1);
        repeat (5) @(negedge clk);
        bus.START     = 1'b1;
        bus.OP        = DIV_OP_REMU;
        bus.OPERAND_A = 32'd9;
        bus.OPERAND_B = 32'd4;
        bus.DEST_ADDR = 5'd9;
        @(negedge clk);
        bus.START = 1'b0;
        n = 0;
        while (bus.BUSY && n < 60) begin
            n++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("ignored_start_busy", {31'd0, bus.BUSY}, 32'd0);

        // RESET mid-CALC: everything clears, no DONE.
        issue(DIV_OP_REM, 32'hDEAD_BEEF, 32'd13, 5'd21, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_busy",   {31'd0, bus.BUSY}, 32'd0);
        check("midreset_done",   {31'd0, bus.DONE}, 32'd0);
        check("midreset_result", bus.RESULT, 32'd0);
        check("midreset_wb",     {27'd0, bus.WB_ADDRESS}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Randomized operations with a bias toward the corner cases.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 20);
                3: rb = -($urandom_range(1, 20));
                default: ;
            endcase
            run_op(rop, ra, rb, 5'($urandom));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL timeout: simulation did not reach the end within the time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_div_unit

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the EX stage.
- Consumes the rs1/rs2 operands read from the register file (via ID/EX). Returns a 32-bit result plus destination tag toward writeback.
- Radix-2 restoring algorithm, one quotient bit per cycle. The hazard unit stalls the pipeline on BUSY.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  synchronous active-high reset.
- START  input  1  request; sampled only in IDLE.
- OP  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- OPERAND_A  input  32  dividend (rs1 data).
- OPERAND_B  input  32  divisor (rs2 data).
- DEST_ADDR  input  5  rd address captured with START.
- FLUSH  input  1  kill in-flight operation (branch mispredict/trap).
- BUSY  output  1  high while an operation is accepted and not finished.
- DONE  output  1  one-cycle pulse, RESULT/WB_ADDRESS valid.
- RESULT  output  32  quotient or remainder.
- WB_ADDRESS  output  5  captured DEST_ADDR, held with RESULT.

Behaviour:
- One clock CLK; reset RESET is synchronous, active-high. On RESET: state IDLE, BUSY=0, DONE=0, RESULT=0, WB_ADDRESS=0, counter=0. Applies mid-operation; no DONE is issued for the aborted op.
- States: IDLE, CALC, FIN.
- IDLE, START=1, FLUSH=0 at edge E0:
  - Latch OP and DEST_ADDR.
  - Compute absolute values for signed ops (DIV/REM) and record the result sign. The quotient is negative when the operand signs differ; the remainder takes the dividend's sign.
- Fast path at E0:
  - B==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result OPERAND_A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, signed op): DIV result 0x80000000, REM result 0.
  - Result registered at E0; DONE=1 for the cycle after E0; state stays IDLE; BUSY never asserts.
- Normal path at E0: go to CALC; BUSY=1 from E0; counter=0; remainder=0; quotient register=|A|.
- CALC, one edge per iteration (E1..E32):
  - Shift {rem,quo} left one bit.
  - Trial subtract |B| using a 33-bit subtract. If non-negative, keep the difference and set quo[0]=1.
  - After counter reaches 31 (edge E32), go to FIN.
- FIN at E33: apply sign correction (two's complement), select quotient or remainder by OP[1], register RESULT, DONE=1 for one cycle, BUSY=0, return to IDLE.
- Latency: DONE is high in the cycle after E33 (33 edges after START acceptance). Fast path takes 1 edge.
- RESULT and WB_ADDRESS hold their value until the next completion; they are not cleared when DONE drops.
- START while BUSY=1 is ignored; no queuing.
- A new START may be accepted in the same cycle DONE is high (back-to-back ops).
- FLUSH=1 in any state:
  - Next state IDLE, BUSY=0, DONE=0; RESULT is not updated.
  - FLUSH has priority over a simultaneous START, which is dropped.
  - FLUSH and RESET together: reset behaviour applies.
- Inputs OPERAND_A/B/OP/DEST_ADDR are only sampled at acceptance and may change afterward.
- The unit does not enforce x0 rules; DEST_ADDR=0 is passed through and the register file write path handles it.

Decomposition:
- Shared package holds:
  - OP encodings: DIV_OP_DIV=2'b00, DIV_OP_DIVU=2'b01, DIV_OP_REM=2'b10, DIV_OP_REMU=2'b11.
  - State encodings: IDLE/CALC/FIN.
  - Constants XLEN=32, DIV_ZERO_Q=32'hFFFFFFFF, INT_MIN=32'h80000000.
- One natural sub-module, div_special_case: combinational detection of divide-by-zero/overflow and the fast-path result. The FSM and datapath stay in div_unit.

Test Plan:
- DIV A=0xFFFFFFF9 (-7), B=2 -> RESULT 0xFFFFFFFD (-3), DONE pulse exactly 33 edges after acceptance, BUSY high for 33 cycles. REM with same operands -> 0xFFFFFFFF (-1).
- DIVU A=0xFFFFFFFF, B=0x10 -> RESULT 0x0FFFFFFF. REMU with same operands -> 0x0000000F. WB_ADDRESS equals DEST_ADDR=5'd7 captured at START.
- Divide by zero: DIV A=5, B=0 -> 0xFFFFFFFF; REMU A=5, B=0 -> 5. DONE one cycle after START, BUSY stays 0.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Both on the 1-cycle fast path.
- FLUSH on the 10th CALC cycle -> BUSY low next cycle, no DONE, RESULT unchanged. The next START (DIVU 100/7) completes with 14 after 33 edges.
- RESET asserted mid-CALC -> all outputs 0 next edge, no DONE. START during BUSY is ignored. Back-to-back START in the DONE cycle is accepted.
